// File: rtl/conv_mem_bridge.sv
// conv_mem_bridge: single-outstanding read bridge from the convolution unit to the core data-memory port.
// Optional request timeout with stale-response discard is enabled by defining CONV_BRIDGE_TIMEOUT_EN.
module conv_mem_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_rd_i,
    input  logic [31:0] req_addr_i,
    output logic        req_ack_o,
    output logic [31:0] req_data_o,
    output logic        req_error_o,
    output logic        dmem_rd_o,
    output logic [31:0] dmem_addr_o,
    input  logic        dmem_accept_i,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_data_i,
    input  logic        dmem_error_i,
    output logic        busy_o,
    output logic [15:0] reads_o
);

    // state | meaning
    // IDLE  | waiting for req_rd_i; address latched on acceptance
    // ISSUE | dmem_rd_o held until the memory accepts
    // WAIT  | read accepted, waiting for dmem_ack_i
    // RESP  | one-cycle req_ack_o pulse, then back to IDLE
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        err_q;
    logic [15:0] reads_q;
    logic        misaligned;
    logic        req_take;
    logic        tmo_hit;
    logic        stale_q;

    assign misaligned = (req_addr_i[1:0] != 2'b00);
    assign req_take   = (state_q == IDLE) && req_rd_i && !stale_q;

`ifdef CONV_BRIDGE_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmo_cnt_q;

    assign tmo_hit = ((state_q == ISSUE) || (state_q == WAIT)) &&
                     (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
        end else if (req_take) begin
            tmo_cnt_q <= '0;
        end else if (((state_q == ISSUE) || (state_q == WAIT)) && !tmo_hit) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    // A timeout in WAIT leaves a read outstanding at the memory; its late ack must be swallowed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stale_q <= 1'b0;
        end else if (stale_q && dmem_ack_i) begin
            stale_q <= 1'b0;
        end else if ((state_q == WAIT) && tmo_hit && !dmem_ack_i) begin
            stale_q <= 1'b1;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
    assign tmo_hit    = 1'b0;
    assign stale_q    = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_take) begin
                    state_d = misaligned ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (dmem_accept_i) begin
                    state_d = WAIT;
                end else if (tmo_hit) begin
                    state_d = RESP;
                end
            end
            WAIT: begin
                if (dmem_ack_i || tmo_hit) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dmem_rd_o   = 1'b0;
        dmem_addr_o = '0;
        req_ack_o   = 1'b0;
        req_error_o = 1'b0;
        req_data_o  = '0;
        case (state_q)
            ISSUE: begin
                dmem_rd_o   = 1'b1;
                dmem_addr_o = {addr_q[31:2], 2'b00};
            end
            RESP: begin
                req_ack_o   = 1'b1;
                req_error_o = err_q;
                req_data_o  = err_q ? 32'h0 : data_q;
            end
            default: ;
        endcase
    end

    assign busy_o  = (state_q != IDLE);
    assign reads_o = reads_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            reads_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_take) begin
                        addr_q <= req_addr_i;
                        err_q  <= misaligned;
                        data_q <= '0;
                    end
                end
                ISSUE: begin
                    if (!dmem_accept_i && tmo_hit) begin
                        err_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (dmem_ack_i) begin
                        data_q <= dmem_data_i;
                        err_q  <= dmem_error_i;
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (!err_q && (reads_q != 16'hFFFF)) begin
                        reads_q <= reads_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mem_bridge.sv
// tb_conv_mem_bridge: scoreboard bench for conv_mem_bridge with a behavioural data-memory responder.
// The timeout scenario runs only when CONV_BRIDGE_TIMEOUT_EN is defined.
module tb_conv_mem_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_rd_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic        req_ack_o;
    logic [31:0] req_data_o;
    logic        req_error_o;
    logic        dmem_rd_o;
    logic [31:0] dmem_addr_o;
    logic        dmem_accept_i = 1'b0;
    logic        dmem_ack_i = 1'b0;
    logic [31:0] dmem_data_i = '0;
    logic        dmem_error_i = 1'b0;
    logic        busy_o;
    logic [15:0] reads_o;

    always #5 clk_i = ~clk_i;

    conv_mem_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_rd_i     (req_rd_i),
        .req_addr_i   (req_addr_i),
        .req_ack_o    (req_ack_o),
        .req_data_o   (req_data_o),
        .req_error_o  (req_error_o),
        .dmem_rd_o    (dmem_rd_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_accept_i(dmem_accept_i),
        .dmem_ack_i   (dmem_ack_i),
        .dmem_data_i  (dmem_data_i),
        .dmem_error_i (dmem_error_i),
        .busy_o       (busy_o),
        .reads_o      (reads_o)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_reads = '0;

    // memory responder knobs and statistics
    int          stall_cycles = 0;
    int          ack_delay = 0;
    bit          mem_err = 1'b0;
    bit          withhold = 1'b0;
    int          rd_cycles = 0;
    int          accepts = 0;
    int          acks_sent = 0;
    int          addr_glitch = 0;
    logic [31:0] last_acc_addr = '0;
    bit          pending = 1'b0;
    bit          in_issue = 1'b0;
    int          pend_cnt = 0;
    int          stall_left = 0;
    logic [31:0] acc_addr = '0;
    logic [31:0] pend_addr = '0;
    logic [31:0] issue_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0000_1000) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
    endfunction

    always @(negedge clk_i) begin
        if (dmem_ack_i) begin
            dmem_ack_i   = 1'b0;
            dmem_data_i  = '0;
            dmem_error_i = 1'b0;
        end
        if (dmem_accept_i) begin
            dmem_accept_i = 1'b0;
            pending       = 1'b1;
            pend_addr     = acc_addr;
            pend_cnt      = ack_delay;
            accepts++;
            last_acc_addr = acc_addr;
        end
        if (pending && !withhold) begin
            if (pend_cnt == 0) begin
                dmem_ack_i   = 1'b1;
                dmem_data_i  = mem_word(pend_addr);
                dmem_error_i = mem_err;
                pending      = 1'b0;
                acks_sent++;
            end else begin
                pend_cnt--;
            end
        end
        if (dmem_rd_o) begin
            rd_cycles++;
            if (!in_issue) begin
                in_issue   = 1'b1;
                stall_left = stall_cycles;
                issue_addr = dmem_addr_o;
            end else if (dmem_addr_o != issue_addr) begin
                addr_glitch++;
            end
            if (stall_left > 0) begin
                stall_left--;
            end else begin
                dmem_accept_i = 1'b1;
                acc_addr      = dmem_addr_o;
                in_issue      = 1'b0;
            end
        end else begin
            in_issue = 1'b0;
        end
    end

    task automatic wait_ack(input int bound, output bit got, output logic [31:0] d,
                            output logic e, output int lat);
        got = 1'b0;
        d   = '0;
        e   = 1'b0;
        lat = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk_i);
            lat++;
            if (req_ack_o) begin
                got = 1'b1;
                d   = req_data_o;
                e   = req_error_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [83:0] outs;
        #2;
        outs = {req_ack_o, req_error_o, req_data_o, dmem_rd_o, dmem_addr_o, busy_o, reads_o};
        total++;
        if (outs !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got=%h want=0", outs);
        end
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_busy: got=%b want=0", busy_o);
        end
    endtask

    task automatic test_single();
        bit got; logic [31:0] d; logic e; int lat; exp_t x;
        req_addr_i = 32'h0000_1000;
        req_rd_i   = 1'b1;
        sb.push_back('{32'hDEAD_BEEF, 1'b0, 3});
        wait_ack(20, got, d, e, lat);
        req_rd_i = 1'b0;
        x = sb.pop_front();
        total++;
        if (!got) begin
            bad++;
            $display("FAIL single_ack: got=no ack want=ack");
        end else begin
            total++;
            if (d !== x.data) begin bad++; $display("FAIL single_data: got=%h want=%h", d, x.data); end
            total++;
            if (e !== x.err) begin bad++; $display("FAIL single_err: got=%b want=%b", e, x.err); end
            total++;
            if (lat != x.lat) begin bad++; $display("FAIL single_latency: got=%0d want=%0d", lat, x.lat); end
        end
        exp_reads++;
        @(negedge clk_i);
        total++;
        if (reads_o !== exp_reads) begin
            bad++;
            $display("FAIL single_reads: got=%0d want=%0d", reads_o, exp_reads);
        end
    endtask

    task automatic test_misaligned();
        bit got; logic [31:0] d; logic e; int lat; exp_t x; int rd0;
        rd0 = rd_cycles;
        req_addr_i = 32'h0000_1002;
        req_rd_i   = 1'b1;
        sb.push_back('{32'h0, 1'b1, 1});
        wait_ack(20, got, d, e, lat);
        req_rd_i = 1'b0;
        x = sb.pop_front();
        total++;
        if (!got) begin
            bad++;
            $display("FAIL misaligned_ack: got=no ack want=ack");
        end else begin
            total++;
            if ({e, d} !== {x.err, x.data}) begin
                bad++;
                $display("FAIL misaligned_resp: got err=%b data=%h want err=%b data=%h", e, d, x.err, x.data);
            end
            total++;
            if (lat != x.lat) begin bad++; $display("FAIL misaligned_latency: got=%0d want=%0d", lat, x.lat); end
        end
        @(negedge clk_i);
        total++;
        if (rd_cycles != rd0) begin
            bad++;
            $display("FAIL misaligned_no_rd: got=%0d rd cycles want=0", rd_cycles - rd0);
        end
        total++;
        if (reads_o !== exp_reads) begin
            bad++;
            $display("FAIL misaligned_reads: got=%0d want=%0d", reads_o, exp_reads);
        end
    endtask

    task automatic test_stall_error();
        bit got; logic [31:0] d; logic e; int lat; exp_t x; int rd0; int gl0;
        rd0 = rd_cycles;
        gl0 = addr_glitch;
        stall_cycles = 5;
        mem_err      = 1'b1;
        req_addr_i   = 32'h0000_1004;
        req_rd_i     = 1'b1;
        sb.push_back('{32'h0, 1'b1, 8});
        @(negedge clk_i);
        // drop the request and scramble the address once it has been latched
        req_rd_i   = 1'b0;
        req_addr_i = 32'hFFFF_FFF1;
        wait_ack(30, got, d, e, lat);
        lat++;
        x = sb.pop_front();
        total++;
        if (!got) begin
            bad++;
            $display("FAIL stall_ack: got=no ack want=ack");
        end else begin
            total++;
            if ({e, d} !== {x.err, x.data}) begin
                bad++;
                $display("FAIL stall_resp: got err=%b data=%h want err=%b data=%h", e, d, x.err, x.data);
            end
            total++;
            if (lat != x.lat) begin bad++; $display("FAIL stall_latency: got=%0d want=%0d", lat, x.lat); end
        end
        total++;
        if (rd_cycles - rd0 != 6) begin
            bad++;
            $display("FAIL stall_rd_cycles: got=%0d want=6", rd_cycles - rd0);
        end
        total++;
        if ((addr_glitch != gl0) || (last_acc_addr !== 32'h0000_1004)) begin
            bad++;
            $display("FAIL stall_addr: got glitches=%0d addr=%h want glitches=0 addr=00001004",
                     addr_glitch - gl0, last_acc_addr);
        end
        stall_cycles = 0;
        mem_err      = 1'b0;
        @(negedge clk_i);
        total++;
        if (reads_o !== exp_reads) begin
            bad++;
            $display("FAIL stall_reads: got=%0d want=%0d", reads_o, exp_reads);
        end
    endtask

    task automatic test_back_to_back();
        bit got; logic [31:0] d; logic e; int lat; exp_t x; int acc0; logic [31:0] a;
        acc0 = accepts;
        a = 32'h0000_2000;
        req_addr_i = a;
        req_rd_i   = 1'b1;
        sb.push_back('{mem_word(a), 1'b0, 3});
        for (int i = 0; i < 9; i++) begin
            wait_ack(20, got, d, e, lat);
            if (i < 8) begin
                a = a + 32'd4;
                req_addr_i = a;
                sb.push_back('{mem_word(a), 1'b0, 4});
            end else begin
                req_rd_i = 1'b0;
            end
            x = sb.pop_front();
            total++;
            if (!got) begin
                bad++;
                $display("FAIL b2b_ack[%0d]: got=no ack want=ack", i);
            end else begin
                total++;
                if ({e, d} !== {x.err, x.data}) begin
                    bad++;
                    $display("FAIL b2b_resp[%0d]: got err=%b data=%h want err=%b data=%h",
                             i, e, d, x.err, x.data);
                end
                total++;
                if (lat != x.lat) begin bad++; $display("FAIL b2b_latency[%0d]: got=%0d want=%0d", i, lat, x.lat); end
            end
            exp_reads++;
        end
        @(negedge clk_i);
        total++;
        if (accepts - acc0 != 9) begin
            bad++;
            $display("FAIL b2b_dmem_reads: got=%0d want=9", accepts - acc0);
        end
        total++;
        if (reads_o !== exp_reads) begin
            bad++;
            $display("FAIL b2b_reads: got=%0d want=%0d", reads_o, exp_reads);
        end
    endtask

`ifdef CONV_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        bit got; logic [31:0] d; logic e; int lat; exp_t x; int rd0; int idle_bad;
        withhold   = 1'b1;
        req_addr_i = 32'h0000_3000;
        req_rd_i   = 1'b1;
        sb.push_back('{32'h0, 1'b1, 5});
        wait_ack(20, got, d, e, lat);
        req_addr_i = 32'h0000_3004;
        x = sb.pop_front();
        total++;
        if (!got) begin
            bad++;
            $display("FAIL timeout_ack: got=no ack want=ack");
        end else begin
            total++;
            if ({e, d, lat} !== {x.err, x.data, x.lat}) begin
                bad++;
                $display("FAIL timeout_resp: got err=%b data=%h lat=%0d want err=%b data=%h lat=%0d",
                         e, d, lat, x.err, x.data, x.lat);
            end
        end
        rd0 = rd_cycles;
        idle_bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (busy_o !== 1'b0) idle_bad++;
        end
        total++;
        if ((idle_bad != 0) || (rd_cycles != rd0)) begin
            bad++;
            $display("FAIL timeout_stale_hold: got busy=%0d rd=%0d want busy=0 rd=0", idle_bad, rd_cycles - rd0);
        end
        withhold = 1'b0;
        sb.push_back('{mem_word(32'h0000_3004), 1'b0, -1});
        wait_ack(30, got, d, e, lat);
        req_rd_i = 1'b0;
        x = sb.pop_front();
        total++;
        if (!got) begin
            bad++;
            $display("FAIL timeout_next_ack: got=no ack want=ack");
        end else begin
            total++;
            if ({e, d} !== {x.err, x.data}) begin
                bad++;
                $display("FAIL timeout_next_resp: got err=%b data=%h want err=%b data=%h", e, d, x.err, x.data);
            end
        end
        exp_reads++;
        @(negedge clk_i);
        total++;
        if (reads_o !== exp_reads) begin
            bad++;
            $display("FAIL timeout_reads: got=%0d want=%0d", reads_o, exp_reads);
        end
    endtask
`endif

    task automatic test_reset_mid_wait();
        bit got; logic [31:0] d; logic e; int lat; exp_t x; int stray; int ack0;
        logic [83:0] outs;
        ack_delay  = 4;
        req_addr_i = 32'h0000_4000;
        req_rd_i   = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        total++;
        if ({busy_o, dmem_rd_o} !== 2'b10) begin
            bad++;
            $display("FAIL rstwait_in_wait: got busy=%b rd=%b want busy=1 rd=0", busy_o, dmem_rd_o);
        end
        ack0 = acks_sent;
        rst_i    = 1'b1;
        req_rd_i = 1'b0;
        #1;
        outs = {req_ack_o, req_error_o, req_data_o, dmem_rd_o, dmem_addr_o, busy_o, reads_o};
        total++;
        if (outs !== '0) begin
            bad++;
            $display("FAIL rstwait_outputs: got=%h want=0", outs);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        exp_reads = '0;
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if (req_ack_o || busy_o) stray++;
        end
        total++;
        if ((stray != 0) || (acks_sent == ack0)) begin
            bad++;
            $display("FAIL rstwait_discard: got stray=%0d late_acks=%0d want stray=0 late_acks>0",
                     stray, acks_sent - ack0);
        end
        ack_delay  = 0;
        req_addr_i = 32'h0000_4008;
        req_rd_i   = 1'b1;
        sb.push_back('{mem_word(32'h0000_4008), 1'b0, 3});
        wait_ack(20, got, d, e, lat);
        req_rd_i = 1'b0;
        x = sb.pop_front();
        total++;
        if (!got) begin
            bad++;
            $display("FAIL rstwait_next_ack: got=no ack want=ack");
        end else begin
            total++;
            if ({e, d, lat} !== {x.err, x.data, x.lat}) begin
                bad++;
                $display("FAIL rstwait_next_resp: got err=%b data=%h lat=%0d want err=%b data=%h lat=%0d",
                         e, d, lat, x.err, x.data, x.lat);
            end
        end
        exp_reads++;
        @(negedge clk_i);
        total++;
        if (reads_o !== exp_reads) begin
            bad++;
            $display("FAIL rstwait_reads: got=%0d want=%0d", reads_o, exp_reads);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=time limit reached want=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_misaligned();
        test_stall_error();
        test_back_to_back();
`ifdef CONV_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_mem_bridge.md
CONV_MEM_BRIDGE -- requirements
Module: conv_mem_bridge

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, cycles spent in ISSUE+WAIT before a timeout error.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 req_rd_i  input  1  read request from convolution unit, level-held until req_ack_o.
REQ-005 req_addr_i  input  32  byte address of requested word.
REQ-006 req_ack_o  output  1  one-cycle completion pulse.
REQ-007 req_data_o  output  32  read data, valid only while req_ack_o=1.
REQ-008 req_error_o  output  1  qualifies req_ack_o: request failed, req_data_o=0.
REQ-009 dmem_rd_o  output  1  read strobe to core data-memory port.
REQ-010 dmem_addr_o  output  32  word-aligned address to data memory.
REQ-011 dmem_accept_i  input  1  memory accepts dmem_rd_o this cycle.
REQ-012 dmem_ack_i  input  1  read response valid.
REQ-013 dmem_data_i  input  32  read response data.
REQ-014 dmem_error_i  input  1  response error, qualifies dmem_ack_i.
REQ-015 busy_o  output  1  high in any state except IDLE.
REQ-016 reads_o  output  16  count of successful reads, saturating.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, RESP; at most one dmem transaction outstanding.
REQ-018 IDLE: on req_rd_i=1, latch req_addr_i into addr_q; if addr_q[1:0]!=0 go RESP with error, else go ISSUE.
REQ-019 ISSUE: dmem_rd_o=1, dmem_addr_o=addr_q; on dmem_accept_i=1 go WAIT; else stay.
REQ-020 WAIT: on dmem_ack_i=1 capture dmem_data_i into data_q and dmem_error_i into err_q, go RESP.
REQ-021 dmem_ack_i outside WAIT is discarded unless REQ-029 applies.
REQ-022 RESP: req_ack_o=1, req_error_o=err_q, req_data_o=err_q?0:data_q; next state IDLE unconditionally.
REQ-023 Minimum latency: req_rd_i sampled in cycle N, accept in N+1, ack in N+2 -> req_ack_o in N+3; IDLE in N+4 samples the next address.
REQ-024 req_rd_i deasserting after latch does not abort; the transaction completes and req_ack_o still pulses.
REQ-025 req_addr_i changes after latch are ignored until the next IDLE sample.
REQ-026 reads_o increments by 1 in each RESP cycle with req_error_o=0; holds at 16'hFFFF.
REQ-027 When not asserted by the current state, dmem_rd_o=0, dmem_addr_o=0, req_ack_o=0, req_error_o=0, req_data_o=0.

Reset
REQ-028 rst_i=1 forces IDLE immediately, including mid-transaction; all outputs 0, addr_q/data_q/err_q/reads_o/timeout counter/stale flag cleared; a pending dmem response after reset release is discarded.

Configuration
REQ-029 Macro CONV_BRIDGE_TIMEOUT_EN defined: counter cleared on IDLE->ISSUE, increments each cycle in ISSUE/WAIT; at TIMEOUT_CYCLES go RESP with error; if timeout occurred in WAIT set stale flag; while stale, IDLE does not leave for ISSUE and the next dmem_ack_i is discarded and clears stale.
REQ-030 Macro undefined: no counter, no stale flag; ISSUE/WAIT wait indefinitely.

Verification
REQ-031 req_addr_i=0x1000, accept in issue cycle, ack with data 0xDEADBEEF next cycle -> req_ack_o 3 cycles after request, data 0xDEADBEEF, error 0, reads_o=1.
REQ-032 req_addr_i=0x1002 -> req_ack_o 1 cycle later with req_error_o=1, data 0, dmem_rd_o never asserted, reads_o unchanged.
REQ-033 dmem_accept_i held low 5 cycles -> dmem_rd_o high 6 cycles with stable address; ack with dmem_error_i=1 -> req_error_o=1, req_data_o=0.
REQ-034 Nine back-to-back requests 0x2000..0x2020 held by level req_rd_i -> nine ack pulses, each data matching its address, reads_o=9, no duplicate dmem reads.
REQ-035 TIMEOUT_EN, TIMEOUT_CYCLES=4, ack withheld -> error ack after 4 cycles; next request waits in IDLE until late ack arrives, then issues normally.
REQ-036 rst_i asserted in WAIT -> outputs 0 same cycle; following ack ignored; new request after release completes normally.
